// File: rtl/cnn_pkg.sv
// Shared fixed-point definitions for the CNN datapath: word format,
// accumulator width, saturation helper and the dense-layer FSM states.
package cnn_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int FRACTION_BITS = 20;
  localparam int ACC_WIDTH     = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    BIAS,
    WRITE,
    DONE
  } fc_state_e;

  // Clamp a wide accumulator to the signed word range; in-range values
  // keep their low DATA_WIDTH bits unchanged.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] r;
    if ((v[ACC_WIDTH-1:DATA_WIDTH-1] == '0) || (v[ACC_WIDTH-1:DATA_WIDTH-1] == '1)) begin
      r = v[DATA_WIDTH-1:0];
    end else if (v[ACC_WIDTH-1]) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_mac.sv
// Fixed-point multiply-accumulate: registered full-width product, then an
// arithmetic shift by FRAC_BITS and accumulate on the following cycle.
// A separate addend path folds a sign-extended word (e.g. a bias) into the sum.
module fixed_mac #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             mul_en,
  input  logic                             add_en,
  input  logic signed [DATA_W-1:0]         a,
  input  logic signed [COEF_W-1:0]         b,
  input  logic signed [DATA_W-1:0]         addend,
  output logic signed [DATA_W+COEF_W-1:0]  acc
);

  localparam int ACC_W = DATA_W + COEF_W;

  // Arithmetic right shift: drops fraction bits, truncating toward -inf.
  function automatic logic signed [ACC_W-1:0] shift_frac(input logic signed [ACC_W-1:0] p);
    return p >>> FRAC_BITS;
  endfunction

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] term_prod;
  logic signed [ACC_W-1:0] term_add;
  logic signed [ACC_W-1:0] prod_p0_d, prod_p0_q;
  logic signed [ACC_W-1:0] acc_p1_d, acc_p1_q;
  logic                    vld_p0_d, vld_p0_q;

  // Next product/accumulator: the product registered last cycle is added only while valid.
  always_comb begin
    a_ext     = {{COEF_W{a[DATA_W-1]}}, a};
    b_ext     = {{DATA_W{b[COEF_W-1]}}, b};
    term_prod = vld_p0_q ? shift_frac(prod_p0_q) : '0;
    term_add  = add_en ? {{COEF_W{addend[DATA_W-1]}}, addend} : '0;
    prod_p0_d = prod_p0_q;
    vld_p0_d  = 1'b0;
    acc_p1_d  = acc_p1_q + term_prod + term_add;
    if (clr) begin
      prod_p0_d = '0;
      vld_p0_d  = 1'b0;
      acc_p1_d  = '0;
    end else if (mul_en) begin
      prod_p0_d = a_ext * b_ext;
      vld_p0_d  = 1'b1;
    end
  end

  // Stage p0 valid flag (control, reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
    end
  end

  // Stage p0 product and stage p1 accumulator (data, never reset; cleared on demand).
  always_ff @(posedge clk) begin
    prod_p0_q <= prod_p0_d;
    acc_p1_q  <= acc_p1_d;
  end

  assign acc = acc_p1_q;

endmodule

// File: rtl/fc_dense_layer.sv
// Fully-connected output layer: for each output o, streams IN_NUM feature and
// weight words through fixed_mac, adds the bias, writes the saturated logit,
// then pulses done once all OUT_NUM logits are written.
module fc_dense_layer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH    = cnn_pkg::DATA_WIDTH,
  parameter int FRACTION_BITS = cnn_pkg::FRACTION_BITS,
  parameter int IN_NUM        = 128,
  parameter int OUT_NUM       = 10,
  parameter int IN_ADR_WIDTH  = 7,
  parameter int W_ADR_WIDTH   = 11,
  parameter int OUT_ADR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        axisif_in_start,
  output logic                        axisif_out_done,
  output logic [IN_ADR_WIDTH-1:0]     out_adrIn,
  input  logic signed [DATA_WIDTH-1:0] in_dataIn,
  output logic [W_ADR_WIDTH-1:0]      out_adrW,
  input  logic signed [DATA_WIDTH-1:0] in_dataW,
  output logic [OUT_ADR_WIDTH-1:0]    out_adrB,
  input  logic signed [DATA_WIDTH-1:0] in_dataB,
  output logic [OUT_ADR_WIDTH-1:0]    out_adrOut,
  output logic [DATA_WIDTH-1:0]       out_dataOut,
  output logic                        out_wr
);

  localparam logic [IN_ADR_WIDTH-1:0]  I_LAST = IN_ADR_WIDTH'(IN_NUM - 1);
  localparam logic [OUT_ADR_WIDTH-1:0] O_LAST = OUT_ADR_WIDTH'(OUT_NUM - 1);

  fc_state_e                  state_d, state_q;
  logic [IN_ADR_WIDTH-1:0]    i_d, i_q;
  logic [W_ADR_WIDTH-1:0]     wa_d, wa_q;
  logic [OUT_ADR_WIDTH-1:0]   o_d, o_q;
  logic                       mac_clr, mac_mul, mac_add;
  logic signed [2*DATA_WIDTH-1:0] acc;

  fixed_mac #(
    .DATA_W    (DATA_WIDTH),
    .COEF_W    (DATA_WIDTH),
    .FRAC_BITS (FRACTION_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .mul_en (mac_mul),
    .add_en (mac_add),
    .a      (in_dataIn),
    .b      (in_dataW),
    .addend (in_dataB),
    .acc    (acc)
  );

  // Next-state, counter updates and MAC controls; start only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    wa_d    = wa_q;
    o_d     = o_q;
    mac_clr = 1'b0;
    mac_mul = 1'b0;
    mac_add = 1'b0;
    case (state_q)
      IDLE: begin
        if (axisif_in_start) begin
          state_d = MAC;
          i_d     = '0;
          wa_d    = '0;
          o_d     = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_mul = 1'b1;
        i_d     = i_q + 1'b1;
        wa_d    = wa_q + 1'b1;
        if (i_q == I_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = BIAS;
      end
      BIAS: begin
        mac_add = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (o_q == O_LAST) begin
          state_d = DONE;
        end else begin
          o_d     = o_q + 1'b1;
          i_d     = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and address counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      wa_q    <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      wa_q    <= wa_d;
      o_q     <= o_d;
    end
  end

  // Port decode: addresses and data are zero outside the state that uses them.
  always_comb begin
    out_adrIn       = '0;
    out_adrW        = '0;
    out_adrB        = '0;
    out_adrOut      = '0;
    out_dataOut     = '0;
    out_wr          = 1'b0;
    axisif_out_done = 1'b0;
    case (state_q)
      MAC: begin
        out_adrIn = i_q;
        out_adrW  = wa_q;
      end
      BIAS: begin
        out_adrB = o_q;
      end
      WRITE: begin
        out_wr      = 1'b1;
        out_adrOut  = o_q;
        out_dataOut = saturate(acc);
      end
      DONE: begin
        axisif_out_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fc_dense_layer.sv
// Directed bench for fc_dense_layer with IN_NUM=4, OUT_NUM=3: a table of
// memory images with hand-computed logits, plus reset/start corner sequences.
module tb_fc_dense_layer;

  localparam int IN_N  = 4;
  localparam int OUT_N = 3;
  localparam int LAT   = OUT_N * (IN_N + 3);  // edges from start edge to done

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [6:0]  adr_in;
  logic [10:0] adr_w;
  logic [3:0]  adr_b;
  logic [3:0]  adr_out;
  logic [31:0] data_out;
  logic        wr;
  logic [31:0] data_in, data_w, data_b;

  logic [31:0] x_mem [4];
  logic [31:0] w_mem [16];
  logic [31:0] b_mem [4];

  assign data_in = x_mem[adr_in[1:0]];
  assign data_w  = w_mem[adr_w[3:0]];
  assign data_b  = b_mem[adr_b[1:0]];

  always #5 clk = ~clk;

  fc_dense_layer #(
    .IN_NUM  (IN_N),
    .OUT_NUM (OUT_N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .axisif_in_start (start),
    .axisif_out_done (done),
    .out_adrIn       (adr_in),
    .in_dataIn       (data_in),
    .out_adrW        (adr_w),
    .in_dataW        (data_w),
    .out_adrB        (adr_b),
    .in_dataB        (data_b),
    .out_adrOut      (adr_out),
    .out_dataOut     (data_out),
    .out_wr          (wr)
  );

  typedef struct {
    logic [0:3][31:0]  x;
    logic [0:11][31:0] w;
    logic [0:2][31:0]  b;
    logic [0:2][31:0]  e;
  } vec_t;

  vec_t vt [6];

  int n_vec = 0;
  int n_mis = 0;

  // Output monitor, sampled 1 time unit after each rising edge.
  int          cyc = 0;
  int          wr_n = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          b2b = 0;
  logic        prev_wr = 1'b0;
  logic [3:0]  wr_adr [16];
  logic [31:0] wr_dat [16];

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (wr) begin
      if (wr_n < 16) begin
        wr_adr[wr_n] = adr_out;
        wr_dat[wr_n] = data_out;
      end
      wr_n++;
      if (prev_wr) b2b++;
    end
    prev_wr = wr;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int k);
    for (int i = 0; i < 16; i++) w_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = vt[k].x[i];
      b_mem[i] = (i < 3) ? vt[k].b[i] : 32'h0;
    end
    for (int i = 0; i < 12; i++) w_mem[i] = vt[k].w[i];
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_n < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (done_n < target) chk("done timeout", 32'(done_n), 32'(target));
  endtask

  task automatic run_vec(input int k);
    int st;
    load(k);
    wr_n   = 0;
    done_n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    st = cyc;
    wait_done(1);
    repeat (10) @(negedge clk);
    chk($sformatf("v%0d write count", k), 32'(wr_n), 32'(OUT_N));
    chk($sformatf("v%0d done count", k), 32'(done_n), 32'd1);
    chk($sformatf("v%0d done latency", k), 32'(done_cyc - st), 32'(LAT));
    for (int j = 0; j < OUT_N; j++) begin
      chk($sformatf("v%0d wr%0d addr", k, j), {28'h0, wr_adr[j]}, 32'(j));
      chk($sformatf("v%0d wr%0d data", k, j), wr_dat[j], vt[k].e[j]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, st;

    // All ones at 1.0: each logit is 4.0.
    vt[0].x = {4{32'h00100000}};
    vt[0].w = {12{32'h00100000}};
    vt[0].b = {3{32'h00000000}};
    vt[0].e = {3{32'h00400000}};
    // x = 1,2,3,4; row o weights = o+1; bias 0.5 -> 10.5, 20.5, 30.5.
    vt[1].x = {32'h00100000, 32'h00200000, 32'h00300000, 32'h00400000};
    vt[1].w = {{4{32'h00100000}}, {4{32'h00200000}}, {4{32'h00300000}}};
    vt[1].b = {3{32'h00080000}};
    vt[1].e = {32'h00A80000, 32'h01480000, 32'h01E80000};
    // -1.0 * 0.5 in lane 0 only -> -0.5.
    vt[2].x = {32'hFFF00000, 32'h0, 32'h0, 32'h0};
    vt[2].w = {12{32'h00080000}};
    vt[2].b = {3{32'h00000000}};
    vt[2].e = {3{32'hFFF80000}};
    // Per-product truncation toward -inf: -1 LSB * 1 LSB -> -1; +1 LSB * 1 LSB -> 0.
    vt[3].x = {32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0};
    vt[3].w = {32'h1, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h1, 32'h0, 32'h0,
               32'h1, 32'h1, 32'h0, 32'h0};
    vt[3].b = {3{32'h00000000}};
    vt[3].e = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    // 1024.0 squared: positive clamp, negated weights clamp low, zero row passes bias.
    vt[4].x = {4{32'h40000000}};
    vt[4].w = {{4{32'h40000000}}, {4{32'hC0000000}}, {4{32'h00000000}}};
    vt[4].b = {32'h0, 32'h0, 32'h12345678};
    vt[4].e = {32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    // Just past each range edge by one LSB, and exactly at the top edge.
    vt[5].x = {32'h00100000, 32'h0, 32'h0, 32'h0};
    vt[5].w = {32'h00000001, 32'h0, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0};
    vt[5].b = {32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    vt[5].e = {32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    load(0);
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset wr", {31'h0, wr}, 32'h0);
    chk("reset adrIn", {25'h0, adr_in}, 32'h0);
    chk("reset adrW", {21'h0, adr_w}, 32'h0);
    chk("reset adrB", {28'h0, adr_b}, 32'h0);
    chk("reset adrOut", {28'h0, adr_out}, 32'h0);
    chk("reset dataOut", data_out, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Start coincident with reset is dropped.
    wr_n = 0; done_n = 0;
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    repeat (40) @(negedge clk);
    chk("start+rst writes", 32'(wr_n), 32'd0);
    chk("start+rst done", 32'(done_n), 32'd0);

    // Reset during MAC of output 1 aborts the run.
    load(1);
    wr_n = 0; done_n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int t = 0; t < 50 && wr_n < 1; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort writes", 32'(wr_n), 32'd1);
    chk("abort first data", wr_dat[0], 32'h00A80000);
    chk("abort done", 32'(done_n), 32'd0);
    run_vec(1);

    // Second start mid-run ignored; start in DONE ignored; start in following IDLE accepted.
    load(1);
    wr_n = 0; done_n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    st = cyc;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(1);
    d1 = done_cyc;
    chk("midstart latency", 32'(d1 - st), 32'(LAT));
    chk("midstart writes", 32'(wr_n), 32'(OUT_N));
    start = 1'b1;               // held through the DONE cycle and the IDLE cycle
    @(negedge clk);
    @(negedge clk) start = 1'b0;
    wait_done(2);
    repeat (10) @(negedge clk);
    chk("restart latency", 32'(done_cyc - d1), 32'(LAT + 2));
    chk("restart done count", 32'(done_n), 32'd2);
    chk("restart writes", 32'(wr_n), 32'(2 * OUT_N));
    for (int j = 0; j < OUT_N; j++) begin
      chk($sformatf("restart wr%0d addr", j), {28'h0, wr_adr[OUT_N + j]}, 32'(j));
      chk($sformatf("restart wr%0d data", j), wr_dat[OUT_N + j], vt[1].e[j]);
    end

    chk("back-to-back writes", 32'(b2b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
